// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute-stage sequencer that feeds a combinational ALU.
//
// Takes one command at a time (op, addr_r, addr_rw). It reads in_r from addr_r,
// then in_rw from addr_rw, over a shared single-port memory handshake. It presents
// both operands to the ALU from registers for one cycle and captures the result and
// zero flag. It then writes the result back to addr_rw and pulses done_o.
//
// Optional build macro: ALU_EXEC_PERF_EN adds perf_ops_o / perf_stall_o counters.
//
// Ports:
//   clk_i, reset_i               clock, asynchronous active-high reset
//   cmd_valid_i / cmd_ready_o    command handshake
//   cmd_op_i, cmd_addr_r_i, cmd_addr_rw_i   command fields
//   mem_addr_o, mem_rd_o, mem_wr_o, mem_wdata_o, mem_rdata_i, mem_ready_i   memory port
//   alu_op_o, alu_in_r_o, alu_in_rw_o, alu_out_i, alu_is_zero_i             ALU port
//   result_o, zero_flag_o        last captured ALU result / zero flag
//   done_o                       one-cycle pulse after write-back completes
//   perf_ops_o, perf_stall_o     (ALU_EXEC_PERF_EN only) completed ops, memory stall cycles

module alu_exec_stage #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 16
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic [3:0]            cmd_op_i,
   input  logic [ADDR_WIDTH-1:0] cmd_addr_r_i,
   input  logic [ADDR_WIDTH-1:0] cmd_addr_rw_i,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic                  mem_rd_o,
   output logic                  mem_wr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   input  logic                  mem_ready_i,
   output logic [3:0]            alu_op_o,
   output logic [DATA_WIDTH-1:0] alu_in_r_o,
   output logic [DATA_WIDTH-1:0] alu_in_rw_o,
   input  logic [DATA_WIDTH-1:0] alu_out_i,
   input  logic                  alu_is_zero_i,
   output logic [DATA_WIDTH-1:0] result_o,
   output logic                  zero_flag_o,
`ifdef ALU_EXEC_PERF_EN
   output logic [31:0]           perf_ops_o,
   output logic [31:0]           perf_stall_o,
`endif
   output logic                  done_o
);

   typedef enum logic [2:0] {
      StIdle,
      StReadR,
      StReadRw,
      StExec,
      StWrite,
      StDone
   } state_e;

   state_e                  state_q;
   logic                    cmd_ready_q;
   logic                    mem_rd_q;
   logic                    mem_wr_q;
   logic [ADDR_WIDTH-1:0]   mem_addr_q;
   logic [DATA_WIDTH-1:0]   mem_wdata_q;
   logic                    done_q;
   logic [3:0]              op_q;
   logic [ADDR_WIDTH-1:0]   addr_rw_q;
   logic [DATA_WIDTH-1:0]   opnd_r_q;
   logic [DATA_WIDTH-1:0]   opnd_rw_q;
   logic [DATA_WIDTH-1:0]   result_q;
   logic                    zero_q;

   // All outputs are registered and set one state ahead, so each state's memory
   // request is already on the bus in the cycle the state is entered.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= StIdle;
         cmd_ready_q <= 1'b1;
         mem_rd_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         done_q      <= 1'b0;
         op_q        <= '0;
         addr_rw_q   <= '0;
         opnd_r_q    <= '0;
         opnd_rw_q   <= '0;
         result_q    <= '0;
         zero_q      <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (cmd_valid_i) begin
                  op_q        <= cmd_op_i;
                  addr_rw_q   <= cmd_addr_rw_i;
                  mem_addr_q  <= cmd_addr_r_i;
                  mem_rd_q    <= 1'b1;
                  cmd_ready_q <= 1'b0;
                  state_q     <= StReadR;
               end
            end
            StReadR: begin
               if (mem_ready_i) begin
                  opnd_r_q   <= mem_rdata_i;
                  mem_addr_q <= addr_rw_q;
                  state_q    <= StReadRw;
               end
            end
            StReadRw: begin
               if (mem_ready_i) begin
                  opnd_rw_q <= mem_rdata_i;
                  mem_rd_q  <= 1'b0;
                  state_q   <= StExec;
               end
            end
            StExec: begin
               // mem_addr_q still holds addr_rw from the second read.
               result_q    <= alu_out_i;
               zero_q      <= alu_is_zero_i;
               mem_wdata_q <= alu_out_i;
               mem_wr_q    <= 1'b1;
               state_q     <= StWrite;
            end
            StWrite: begin
               if (mem_ready_i) begin
                  mem_wr_q <= 1'b0;
                  done_q   <= 1'b1;
                  state_q  <= StDone;
               end
            end
            StDone: begin
               done_q      <= 1'b0;
               cmd_ready_q <= 1'b1;
               state_q     <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

`ifdef ALU_EXEC_PERF_EN
   logic [31:0] perf_ops_q;
   logic [31:0] perf_stall_q;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         perf_ops_q   <= '0;
         perf_stall_q <= '0;
      end else begin
         if (state_q == StDone) begin
            perf_ops_q <= perf_ops_q + 32'd1;
         end
         if (!mem_ready_i &&
             (state_q == StReadR || state_q == StReadRw || state_q == StWrite)) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
      end
   end

   assign perf_ops_o   = perf_ops_q;
   assign perf_stall_o = perf_stall_q;
`endif

   assign cmd_ready_o = cmd_ready_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_rd_o    = mem_rd_q;
   assign mem_wr_o    = mem_wr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign done_o      = done_q;
   assign alu_op_o    = op_q;
   assign alu_in_r_o  = opnd_r_q;
   assign alu_in_rw_o = opnd_rw_q;
   assign result_o    = result_q;
   assign zero_flag_o = zero_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: self-checking bench for alu_exec_stage.
// Provides a behavioural ALU, a wait-state memory responder and a per-command reference
// (operands read from the bench memory, expected write, expected latency).
// Perf counter checks are compiled only when ALU_EXEC_PERF_EN is defined.

module tb_alu_exec_stage;
   localparam int unsigned DW = 32;
   localparam int unsigned AW = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [3:0]    cmd_op;
   logic [AW-1:0] cmd_addr_r;
   logic [AW-1:0] cmd_addr_rw;
   logic [AW-1:0] mem_addr;
   logic          mem_rd;
   logic          mem_wr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ready;
   logic [3:0]    alu_op;
   logic [DW-1:0] alu_in_r;
   logic [DW-1:0] alu_in_rw;
   logic [DW-1:0] alu_out;
   logic          alu_is_zero;
   logic [DW-1:0] result;
   logic          zero_flag;
   logic          done;
`ifdef ALU_EXEC_PERF_EN
   logic [31:0]   perf_ops;
   logic [31:0]   perf_stall;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_exec_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .cmd_valid_i   (cmd_valid),
      .cmd_ready_o   (cmd_ready),
      .cmd_op_i      (cmd_op),
      .cmd_addr_r_i  (cmd_addr_r),
      .cmd_addr_rw_i (cmd_addr_rw),
      .mem_addr_o    (mem_addr),
      .mem_rd_o      (mem_rd),
      .mem_wr_o      (mem_wr),
      .mem_wdata_o   (mem_wdata),
      .mem_rdata_i   (mem_rdata),
      .mem_ready_i   (mem_ready),
      .alu_op_o      (alu_op),
      .alu_in_r_o    (alu_in_r),
      .alu_in_rw_o   (alu_in_rw),
      .alu_out_i     (alu_out),
      .alu_is_zero_i (alu_is_zero),
      .result_o      (result),
      .zero_flag_o   (zero_flag),
`ifdef ALU_EXEC_PERF_EN
      .perf_ops_o    (perf_ops),
      .perf_stall_o  (perf_stall),
`endif
      .done_o        (done)
   );

   // Behavioural ALU sitting downstream of the stage.
   function automatic logic [DW-1:0] alu_f(input logic [3:0] op, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
      case (op)
         4'h0:    return a + b;
         4'h1:    return a - b;
         4'h2:    return a & b;
         4'h3:    return a | b;
         4'h4:    return a ^ b;
         4'h5:    return a << b[4:0];
         4'h6:    return a >> b[4:0];
         default: return a + b + {28'b0, op};
      endcase
   endfunction

   assign alu_out     = alu_f(alu_op, alu_in_r, alu_in_rw);
   assign alu_is_zero = (alu_out == '0);

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Memory model with a configurable number of wait cycles per access.
   logic [DW-1:0] mem [256];
   logic [AW-1:0] wlog_addr [$];
   logic [DW-1:0] wlog_data [$];
   int            wait_cfg = 0;
   int            wait_cnt = 0;
   bit            stall_prev = 1'b0;
   logic [49:0]   snap;

   initial begin
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if ((mem_rd || mem_wr) && !reset) begin
            if (wait_cnt >= wait_cfg) begin
               mem_ready = 1'b1;
               mem_rdata = mem[mem_addr[7:0]];
            end else begin
               mem_ready = 1'b0;
               mem_rdata = $urandom;
               wait_cnt++;
            end
         end else begin
            mem_ready = 1'b0;
            wait_cnt  = 0;
         end
      end
   end

   // Completion, mutual exclusion and stall-stability monitor (pre-edge values).
   initial begin
      forever begin
         @(posedge clk);
         if (!reset) begin
            if (mem_rd || mem_wr) check_eq("rd_wr_mutex", {63'b0, mem_rd && mem_wr}, 64'd0);
            if (stall_prev) check_eq("stall_stable", {14'b0, mem_addr, mem_rd, mem_wr, mem_wdata},
                                     {14'b0, snap});
            if (mem_ready && (mem_rd || mem_wr)) begin
               wait_cnt = 0;
               if (mem_wr) begin
                  mem[mem_addr[7:0]] = mem_wdata;
                  wlog_addr.push_back(mem_addr);
                  wlog_data.push_back(mem_wdata);
               end
            end
            stall_prev = (mem_rd || mem_wr) && !mem_ready;
            snap       = {mem_addr, mem_rd, mem_wr, mem_wdata};
         end else begin
            stall_prev = 1'b0;
         end
      end
   end

   // Issues one command (call right after a negedge) and checks it end to end.
   // With hold set, the next command is presented while this one is busy.
   task automatic run_op(input logic [3:0] op, input logic [AW-1:0] ar, input logic [AW-1:0] arw,
                         input int waits, input bit hold, input logic [3:0] nop,
                         input logic [AW-1:0] nar, input logic [AW-1:0] narw);
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [DW-1:0] exp;
      int            n;
      wait_cfg    = waits;
      cmd_op      = op;
      cmd_addr_r  = ar;
      cmd_addr_rw = arw;
      cmd_valid   = 1'b1;
      n = 0;
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_eq("accept_ready", {63'b0, cmd_ready}, 64'd1);
      a   = mem[ar[7:0]];
      b   = mem[arw[7:0]];
      exp = alu_f(op, a, b);
      wlog_addr.delete();
      wlog_data.delete();
      @(negedge clk);
      if (hold) begin
         cmd_op      = nop;
         cmd_addr_r  = nar;
         cmd_addr_rw = narw;
      end else begin
         cmd_valid = 1'b0;
      end
      n = 1;
      while (!done && n < 100) begin
         check_eq("busy_ready", {63'b0, cmd_ready}, 64'd0);
         @(negedge clk);
         n++;
      end
      check_eq("done_cycle", 64'(n), 64'(5 + 3 * waits));
      check_eq("done", {63'b0, done}, 64'd1);
      check_eq("result", {32'b0, result}, {32'b0, exp});
      check_eq("zero_flag", {63'b0, zero_flag}, {63'b0, exp == '0});
      check_eq("write_count", 64'(wlog_addr.size()), 64'd1);
      if (wlog_addr.size() > 0) begin
         check_eq("wr_addr", {48'b0, wlog_addr[0]}, {48'b0, arw});
         check_eq("wr_data", {32'b0, wlog_data[0]}, {32'b0, exp});
      end
      check_eq("alu_inputs", {alu_in_r, alu_in_rw}, {a, b});
      check_eq("alu_op", {60'b0, alu_op}, {60'b0, op});
      @(negedge clk);
      check_eq("done_pulse", {63'b0, done}, 64'd0);
      check_eq("ready_back", {63'b0, cmd_ready}, 64'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [3:0]    rop;
      logic [AW-1:0] rar;
      logic [AW-1:0] rarw;
      reset       = 1'b1;
      cmd_valid   = 1'b0;
      cmd_op      = '0;
      cmd_addr_r  = '0;
      cmd_addr_rw = '0;
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      repeat (3) @(negedge clk);

      // Reset state
      check_eq("rst_ready", {63'b0, cmd_ready}, 64'd1);
      check_eq("rst_rd_wr_done", {61'b0, mem_rd, mem_wr, done}, 64'd0);
      check_eq("rst_addr_wdata", {16'b0, mem_addr, mem_wdata}, 64'd0);
      check_eq("rst_alu", {alu_in_r, alu_in_rw}, 64'd0);
      check_eq("rst_op_res", {27'b0, alu_op, zero_flag, result}, 64'd0);
      reset = 1'b0;
      @(negedge clk);

      // ADD, no wait states
      mem[8'h10] = 32'd2536;
      mem[8'h20] = 32'd113;
      run_op(4'h0, 16'h0010, 16'h0020, 0, 1'b0, '0, '0, '0);
      check_eq("add_mem", {32'b0, mem[8'h20]}, 64'd2649);

      // SUB to zero, then nonzero
      mem[8'h10] = 32'd113;
      mem[8'h20] = 32'd113;
      run_op(4'h1, 16'h0010, 16'h0020, 0, 1'b0, '0, '0, '0);
      check_eq("sub_zero", {63'b0, zero_flag}, 64'd1);
      run_op(4'h0, 16'h0010, 16'h0020, 0, 1'b0, '0, '0, '0);
      check_eq("nonzero_flag", {63'b0, zero_flag}, 64'd0);

      // Wait states
      mem[8'h10] = 32'd2536;
      mem[8'h20] = 32'd113;
      run_op(4'h0, 16'h0010, 16'h0020, 3, 1'b0, '0, '0, '0);

      // Busy with a held second command, then aliased addresses
      mem[8'h30] = 32'd5;
      run_op(4'h2, 16'h0010, 16'h0020, 0, 1'b1, 4'h0, 16'h0030, 16'h0030);
      run_op(4'h0, 16'h0030, 16'h0030, 0, 1'b0, '0, '0, '0);
      check_eq("alias_mem", {32'b0, mem[8'h30]}, 64'd10);

      // Randomized commands
      for (int k = 0; k < 24; k++) begin
         rop  = 4'($urandom_range(0, 15));
         rar  = 16'($urandom_range(0, 255));
         rarw = ($urandom_range(0, 3) == 0) ? rar : 16'($urandom_range(0, 255));
         mem[rar[7:0]]  = $urandom;
         mem[rarw[7:0]] = ($urandom_range(0, 3) == 0) ? mem[rar[7:0]] : $urandom;
         if ($urandom_range(0, 3) == 0) rop = 4'h1;
         run_op(rop, rar, rarw, $urandom_range(0, 2), 1'b0, '0, '0, '0);
      end

      // Reset in the second WRITE wait cycle
      mem[8'h10] = 32'd2536;
      mem[8'h20] = 32'd113;
      wait_cfg    = 3;
      cmd_op      = 4'h0;
      cmd_addr_r  = 16'h0010;
      cmd_addr_rw = 16'h0020;
      cmd_valid   = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      wlog_addr.delete();
      n = 0;
      while (!mem_wr && n < 60) begin
         @(negedge clk);
         n++;
      end
      check_eq("reach_write", {63'b0, mem_wr}, 64'd1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_eq("abort_wr", {63'b0, mem_wr}, 64'd0);
      check_eq("abort_ready", {63'b0, cmd_ready}, 64'd1);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check_eq("abort_no_done", {63'b0, done}, 64'd0);
      end
      check_eq("abort_no_write", 64'(wlog_addr.size()), 64'd0);
      check_eq("abort_state", {30'b0, cmd_ready, zero_flag, result}, {30'b0, 2'b10, 32'd0});
      check_eq("abort_mem", {32'b0, mem[8'h20]}, 64'd113);

`ifdef ALU_EXEC_PERF_EN
      run_op(4'h0, 16'h0010, 16'h0020, 3, 1'b0, '0, '0, '0);
      run_op(4'h0, 16'h0010, 16'h0020, 3, 1'b0, '0, '0, '0);
      check_eq("perf_ops", {32'b0, perf_ops}, 64'd2);
      check_eq("perf_stall", {32'b0, perf_stall}, 64'd18);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute-stage sequencer that sits directly upstream of the combinational ALU and feeds it.
- Accepts one operation command: a 4-bit ALU op, a source address `addr_r` and a read/write address `addr_rw`.
- Fetches both operands over a shared single-port memory handshake, drives the ALU, captures its result and zero flag, and writes the result back to `addr_rw`.
- One command in flight at a time.

Parameters:
- DATA_WIDTH, 32, operand/result width; must match the ALU.
- ADDR_WIDTH, 16, memory address width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  stage can accept a command.
- cmd_op  input  4  ALU op code, passed through unchanged.
- cmd_addr_r  input  ADDR_WIDTH  address of first operand (`in_r`).
- cmd_addr_rw  input  ADDR_WIDTH  address of second operand (`in_rw`) and the result destination.
- mem_addr  output  ADDR_WIDTH  memory address.
- mem_rd  output  1  read request.
- mem_wr  output  1  write request.
- mem_wdata  output  DATA_WIDTH  write data.
- mem_rdata  input  DATA_WIDTH  read data, valid when mem_ready=1 during mem_rd.
- mem_ready  input  1  current request completes this cycle.
- alu_op  output  4  to ALU `op`.
- alu_in_r  output  DATA_WIDTH  to ALU `in_r`.
- alu_in_rw  output  DATA_WIDTH  to ALU `in_rw`.
- alu_out  input  DATA_WIDTH  from ALU `out`.
- alu_is_zero  input  1  from ALU `is_zero`.
- result  output  DATA_WIDTH  last captured ALU result.
- zero_flag  output  1  last captured ALU zero flag.
- done  output  1  one-cycle pulse when write-back completes.

Behaviour:
- Reset values (async, applied immediately): state=IDLE; cmd_ready=1; mem_rd=0; mem_wr=0; mem_addr=0; mem_wdata=0; done=0; alu_op=0; alu_in_r=0; alu_in_rw=0; result=0; zero_flag=0.
- States:
  - IDLE: cmd_ready=1. On cmd_valid & cmd_ready, latch op and both addresses, then go to READ_R. cmd_ready=0 in every other state.
  - READ_R: mem_rd=1, mem_addr=addr_r. On mem_ready, register mem_rdata into opnd_r, then go to READ_RW. Otherwise hold all outputs.
  - READ_RW: mem_rd=1, mem_addr=addr_rw. On mem_ready, register into opnd_rw, then go to EXEC.
  - EXEC: one cycle; alu_* outputs are already stable from registers. Capture alu_out into result and alu_is_zero into zero_flag, then go to WRITE.
  - WRITE: mem_wr=1, mem_addr=addr_rw, mem_wdata=result. On mem_ready, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- ALU drive: alu_op, alu_in_r and alu_in_rw are driven only from internal registers, never directly from cmd_* or mem_rdata. They hold their values after the operation until the next fetch overwrites them.
- Mutual exclusion: mem_rd and mem_wr are never high together. Both are low in IDLE, EXEC and DONE.
- Latency (mem_ready tied 1, accept in cycle 0):
  - READ_R in cycle 1, READ_RW in cycle 2, EXEC in cycle 3, WRITE in cycle 4.
  - done=1 in cycle 5; cmd_ready=1 again in cycle 6.
  - Each mem wait cycle adds one cycle.
- addr_r == addr_rw: both reads are still performed, and the result overwrites that address.
- cmd_valid while busy: ignored, with no side effects. The upstream block must hold cmd_valid until accepted.
- result and zero_flag: change only in EXEC; they persist through IDLE.
- Op codes are not decoded; any 4-bit value is forwarded, and the written value is whatever the ALU returns.
- Reset mid-operation: abort immediately and go to IDLE. No write is issued (mem_wr drops asynchronously), and no done pulse is produced.

Optional Feature:
- Macro: ALU_EXEC_PERF_EN.
- When defined:
  - Adds output `perf_ops` [31:0], which counts completed operations and increments in the DONE cycle.
  - Adds output `perf_stall` [31:0], which counts cycles spent in READ_R/READ_RW/WRITE with mem_ready=0.
  - Both counters reset to 0 and wrap modulo 2^32.
- When undefined: neither port nor counter exists, and all other behaviour is identical.

Test Plan:
1. ADD, no wait states. mem[0x10]=2536, mem[0x20]=113, op=0000, addr_r=0x10, addr_rw=0x20, mem_ready=1 → exactly one write of 2649 to 0x20; result=2649, zero_flag=0; done in cycle 5.
2. SUB giving zero. mem[0x10]=113, mem[0x20]=113, op=0001 → write 0 to 0x20; zero_flag=1. Then run an op giving a nonzero result → zero_flag=0.
3. Wait states. Same as scenario 1 but mem_ready held low 3 cycles on each of the three accesses → done in cycle 14; mem_addr/mem_rd/mem_wr stable while waiting.
4. Busy and alias. cmd_valid held high with a second command during the operation → second command accepted only in the cycle after done. addr_r=addr_rw=0x30, mem[0x30]=5, op=0000 → mem[0x30]=10.
5. Reset mid-operation. Assert reset in the 2nd WRITE wait cycle → mem_wr=0 immediately; no done; after release cmd_ready=1, result=0, zero_flag=0.
6. ALU_EXEC_PERF_EN build: scenario 3 run twice → perf_ops=2, perf_stall=18. Without the macro, the bench compiles without the perf ports.
